accum_sequencer: RTL and testbench
==================================

Name: accum_sequencer

Overview:
- Sequences one accumulator_array across a K-split matmul tile: NUM_ROWS row-vectors × NUM_PASSES partial-sum passes.
- Issues skewed per-lane accumulator commands and drives the partial-sum (psum) buffer read/write addresses.
- Stalls the MXU output stream on psum read-after-write hazards.
- Sits between the systolic array's row-valid stream, accumulator_array and the psum SRAM.

Parameters:
- NUM_DATA, ARRAY_DIMENSION: lane count; lane gi is skewed gi cycles from lane 0.
- ADD_LATENCY, ACCUM_ADDER_LATENCY (package constant): fsize_adder latency in cycles.
- ROW_W, 8: row counter width; max 255 rows per tile.
- PASS_W, 16: pass counter width.

Ports:
- clk  in  1  clock.
- rstn  in  1  async active-low reset.
- cfg_valid  in  1  tile config offered.
- cfg_ready  out  1  config accepted when high with cfg_valid.
- cfg_rows  in  ROW_W  rows per pass.
- cfg_passes  in  PASS_W  accumulation passes.
- mxu_valid  in  1  lane-0 row vector available.
- mxu_ready  out  1  beat consumed when valid&&ready.
- command_array  out  ACCUM_COMMAND_WIDTH×[0:NUM_DATA-1]  per-lane accumulator command.
- psum_rd_en  out  1  psum read strobe; 1-cycle sync read.
- psum_rd_addr  out  ROW_W  psum read row.
- psum_wr_en  out  1  psum writeback strobe, lane-0 timing.
- psum_wr_addr  out  ROW_W  psum writeback row.
- out_valid  out  1  final-pass result row valid, lane-0 timing.
- out_addr  out  ROW_W  final result row index.
- busy  out  1  state != IDLE.
- done  out  1  one-cycle pulse at tile completion.
- err_overrun  out  1  sticky: mxu_valid seen outside RUN.

Behaviour:
- Reset (async, rstn=0):
  - State IDLE; all counters and delay lines cleared.
  - Every command_array lane = ACCUMULATOR_COMMAND_IDLE.
  - All strobes, busy, done and err_overrun = 0.
  - In-flight beats are discarded; a reset mid-tile leaves the psum contents undefined.
- PIPE_LAT = ADD_LATENCY + 2, covering the accumulator input register and output register.
- FSM IDLE → RUN → DRAIN → DONE → IDLE:
  - IDLE: cfg_ready=1. On cfg_valid, latch rows/passes, set r=0, p=0, clear err_overrun.
    - rows==0 or passes==0: go straight to DONE.
    - Otherwise go to RUN.
  - RUN: mxu_ready = (p==0) || (inflight < rows).
    - Accepted beat at cycle t: if p>0, psum_rd_en=1 with psum_rd_addr=r, at cycle t.
    - Lane-0 command at t+1: NEW_ACCUM if p==0, else ACCUM. Otherwise IDLE.
    - Lane gi command = lane-0 command delayed gi cycles through a shift register.
    - r increments per beat. When r==rows-1, r wraps to 0 and p increments.
    - After the beat with p==passes-1 and r==rows-1, go to DRAIN.
  - Writeback for a beat accepted at t, asserted at t+1+PIPE_LAT:
    - If its pass < passes-1: psum_wr_en=1, psum_wr_addr=row.
    - Otherwise: out_valid=1, out_addr=row.
    - The psum buffer and downstream logic apply the same per-lane skew.
    - Row index and final flag travel in a PIPE_LAT+1 deep tag pipe.
  - inflight counter:
    - +1 on each accepted beat.
    - -1 at t+1+PIPE_LAT+NUM_DATA-1, when the last lane retires.
    - A simultaneous increment and decrement leaves it unchanged.
    - The decrement is visible to mxu_ready in the next cycle.
  - Hazard rule: the psum write at cycle W is readable by a read issued at W+1 or later.
  - DRAIN: mxu_ready=0; wait until inflight==0, then go to DONE.
  - DONE: done=1 for one cycle, then IDLE. cfg_ready=0 in this state.
- Boundary cases:
  - mxu_valid in IDLE, DRAIN or DONE sets err_overrun; the beat is ignored and no command is issued.
  - passes==1: no psum reads or writes; every result goes to out_valid.
  - rows==1: every beat of pass>0 stalls until the previous beat fully retires.
  - cfg_valid while busy is ignored, because cfg_ready=0.

Decomposition:
- SPARQ_PKG additions:
  - ACCUM_ADDER_LATENCY constant.
  - accum_seq_state_t enum (IDLE, RUN, DRAIN, DONE).
  - ACCUMULATOR_COMMAND_IDLE encoding, if not already present.
- Sub-module skew_delay_line: generic per-lane shift register for commands. Reused by the psum buffer for write skew.

Test Plan:
NUM_DATA=4, ADD_LATENCY=8, PIPE_LAT=10.
- rows=4, passes=1, mxu_valid high cycles 0–3:
  - lane-0 NEW_ACCUM at cycles 1–4; lane-3 at 4–7.
  - out_valid at cycles 11–14 with out_addr 0..3.
  - No psum strobes; done at 19.
- rows=8, passes=3, continuous valid:
  - Pass 0 issues NEW_ACCUM; passes 1–2 issue ACCUM.
  - psum_rd_addr and psum_wr_addr cycle 0..7 twice.
  - out_valid 8 times; stall cycles observed only where inflight ≥ 8.
- rows=1, passes=4, continuous valid: accepted beats exactly 15 cycles apart (0, 15, 30, 45); each read follows the matching write by ≥1 cycle.
- cfg_rows=0, passes=5: done pulses 1 cycle after config acceptance; no commands or strobes.
- mxu_valid pulsed in IDLE: err_overrun=1 and stays set; the next cfg acceptance clears it.
- rstn low mid-RUN, at cycle 5 of the rows=8 case: all lanes IDLE immediately; busy=0; a new config runs cleanly from r=0, p=0.

Source files
------------

// File: rtl/accum_sequencer_pkg.sv
// Shared constants and types for the accumulator sequencer: adder latency,
// accumulator command encodings and the sequencer state enum.
package accum_sequencer_pkg;

  localparam int ACCUM_ADDER_LATENCY = 8;
  localparam int ACCUM_COMMAND_WIDTH = 2;

  localparam logic [ACCUM_COMMAND_WIDTH-1:0] ACCUMULATOR_COMMAND_IDLE      = 2'd0;
  localparam logic [ACCUM_COMMAND_WIDTH-1:0] ACCUMULATOR_COMMAND_NEW_ACCUM = 2'd1;
  localparam logic [ACCUM_COMMAND_WIDTH-1:0] ACCUMULATOR_COMMAND_ACCUM     = 2'd2;

  typedef enum logic [1:0] {
    SEQ_IDLE  = 2'd0,
    SEQ_RUN   = 2'd1,
    SEQ_DRAIN = 2'd2,
    SEQ_DONE  = 2'd3
  } accum_seq_state_t;

endpackage

// File: rtl/accum_sequencer_skew_delay_line.sv
// Per-lane skew line: lane i sees lane0_in delayed by i cycles (lane 0 is
// combinational pass-through). Also used by the psum buffer for write skew.
module accum_sequencer_skew_delay_line #(
  parameter int WIDTH     = 2,
  parameter int NUM_LANES = 4
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [WIDTH-1:0] lane0_in,
  output logic [WIDTH-1:0] lane_out [0:NUM_LANES-1]
);

  localparam int DEPTH = (NUM_LANES > 1) ? NUM_LANES - 1 : 1;

  logic [WIDTH-1:0] stage_q [0:DEPTH-1];
  logic [WIDTH-1:0] stage_d [0:DEPTH-1];

  always_comb begin
    stage_d[0] = lane0_in;
    for (int i = 1; i < DEPTH; i++) begin
      stage_d[i] = stage_q[i-1];
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < DEPTH; i++) begin
        stage_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        stage_q[i] <= stage_d[i];
      end
    end
  end

  always_comb begin
    lane_out[0] = lane0_in;
    for (int i = 1; i < NUM_LANES; i++) begin
      lane_out[i] = stage_q[i-1];
    end
  end

endmodule

// File: rtl/accum_sequencer.sv
// Sequences one accumulator array over NUM_ROWS x NUM_PASSES of a K-split tile:
// skewed lane commands, psum read/writeback addressing and RAW-hazard stalls.
module accum_sequencer
  import accum_sequencer_pkg::*;
#(
  parameter int NUM_DATA    = 4,
  parameter int ADD_LATENCY = ACCUM_ADDER_LATENCY,
  parameter int ROW_W       = 8,
  parameter int PASS_W      = 16
) (
  input  logic                           clk,
  input  logic                           rstn,
  // Handshakes: a transfer happens on a rising edge where valid && ready;
  // valid never depends on ready and ready may depend on valid-independent state only.
  input  logic                           cfg_valid,
  output logic                           cfg_ready,
  input  logic [ROW_W-1:0]               cfg_rows,
  input  logic [PASS_W-1:0]              cfg_passes,
  input  logic                           mxu_valid,
  output logic                           mxu_ready,
  output logic [ACCUM_COMMAND_WIDTH-1:0] command_array [0:NUM_DATA-1],
  output logic                           psum_rd_en,
  output logic [ROW_W-1:0]               psum_rd_addr,
  output logic                           psum_wr_en,
  output logic [ROW_W-1:0]               psum_wr_addr,
  output logic                           out_valid,
  output logic [ROW_W-1:0]               out_addr,
  output logic                           busy,
  output logic                           done,
  output logic                           err_overrun,
  output logic [1:0]                     dbg_state
);

  // Input register + adder + output register of the accumulator.
  localparam int PIPE_LAT = ADD_LATENCY + 2;
  // A beat retires when its last lane leaves the accumulator.
  localparam int RET_LEN  = PIPE_LAT + NUM_DATA;
  localparam int INF_W    = ROW_W + 1;

  localparam logic [ROW_W-1:0]  ROW_ONE  = 1;
  localparam logic [PASS_W-1:0] PASS_ONE = 1;
  localparam logic [INF_W-1:0]  INF_ONE  = 1;

  accum_seq_state_t state_q, state_d;

  logic [ROW_W-1:0]  rows_q, rows_d;
  logic [PASS_W-1:0] passes_q, passes_d;
  logic [ROW_W-1:0]  r_q, r_d;
  logic [PASS_W-1:0] p_q, p_d;
  logic [INF_W-1:0]  inflight_q, inflight_d;
  logic              err_q, err_d;
  logic [ACCUM_COMMAND_WIDTH-1:0] cmd0_q, cmd0_d;
  logic [RET_LEN-1:0] ret_q, ret_d;
  logic              tag_last_q [0:PIPE_LAT];
  logic              tag_last_d [0:PIPE_LAT];
  logic [ROW_W-1:0]  tag_row_q  [0:PIPE_LAT];
  logic [ROW_W-1:0]  tag_row_d  [0:PIPE_LAT];

  logic accept;
  logic last_row;
  logic last_pass;
  logic ret_dec;

  assign last_row  = (r_q == rows_q - ROW_ONE);
  assign last_pass = (p_q == passes_q - PASS_ONE);
  assign ret_dec   = ret_q[RET_LEN-1];

  always_comb begin
    state_d      = state_q;
    rows_d       = rows_q;
    passes_d     = passes_q;
    r_d          = r_q;
    p_d          = p_q;
    cfg_ready    = 1'b0;
    mxu_ready    = 1'b0;
    accept       = 1'b0;
    psum_rd_en   = 1'b0;
    psum_rd_addr = r_q;
    done         = 1'b0;
    case (state_q)
      SEQ_IDLE: begin
        cfg_ready = 1'b1;
        if (cfg_valid) begin
          rows_d   = cfg_rows;
          passes_d = cfg_passes;
          r_d      = '0;
          p_d      = '0;
          if (cfg_rows == '0 || cfg_passes == '0) state_d = SEQ_DONE;
          else                                    state_d = SEQ_RUN;
        end
      end
      SEQ_RUN: begin
        // Later passes must not read a row whose previous partial sum is still in flight.
        mxu_ready = (p_q == '0) || (inflight_q < {1'b0, rows_q});
        accept    = mxu_valid && mxu_ready;
        if (accept) begin
          psum_rd_en = (p_q != '0);
          if (last_row) begin
            r_d = '0;
            p_d = p_q + PASS_ONE;
            if (last_pass) state_d = SEQ_DRAIN;
          end else begin
            r_d = r_q + ROW_ONE;
          end
        end
      end
      SEQ_DRAIN: begin
        if (inflight_q == '0) state_d = SEQ_DONE;
      end
      SEQ_DONE: begin
        done    = 1'b1;
        state_d = SEQ_IDLE;
      end
      default: state_d = SEQ_IDLE;
    endcase
  end

  always_comb begin
    err_d = err_q;
    if (state_q == SEQ_IDLE && cfg_valid) err_d = 1'b0;
    if (mxu_valid && state_q != SEQ_RUN)  err_d = 1'b1;

    inflight_d = inflight_q;
    if (accept && !ret_dec)      inflight_d = inflight_q + INF_ONE;
    else if (!accept && ret_dec) inflight_d = inflight_q - INF_ONE;

    if (!accept)           cmd0_d = ACCUMULATOR_COMMAND_IDLE;
    else if (p_q == '0)    cmd0_d = ACCUMULATOR_COMMAND_NEW_ACCUM;
    else                   cmd0_d = ACCUMULATOR_COMMAND_ACCUM;

    ret_d = {ret_q[RET_LEN-2:0], accept};

    tag_last_d[0] = last_pass;
    tag_row_d[0]  = r_q;
    for (int i = 1; i <= PIPE_LAT; i++) begin
      tag_last_d[i] = tag_last_q[i-1];
      tag_row_d[i]  = tag_row_q[i-1];
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= SEQ_IDLE;
      rows_q     <= '0;
      passes_q   <= '0;
      r_q        <= '0;
      p_q        <= '0;
      inflight_q <= '0;
      err_q      <= 1'b0;
      cmd0_q     <= ACCUMULATOR_COMMAND_IDLE;
      ret_q      <= '0;
      for (int i = 0; i <= PIPE_LAT; i++) begin
        tag_last_q[i] <= 1'b0;
        tag_row_q[i]  <= '0;
      end
    end else begin
      state_q    <= state_d;
      rows_q     <= rows_d;
      passes_q   <= passes_d;
      r_q        <= r_d;
      p_q        <= p_d;
      inflight_q <= inflight_d;
      err_q      <= err_d;
      cmd0_q     <= cmd0_d;
      ret_q      <= ret_d;
      for (int i = 0; i <= PIPE_LAT; i++) begin
        tag_last_q[i] <= tag_last_d[i];
        tag_row_q[i]  <= tag_row_d[i];
      end
    end
  end

  accum_sequencer_skew_delay_line #(
    .WIDTH     (ACCUM_COMMAND_WIDTH),
    .NUM_LANES (NUM_DATA)
  ) u_cmd_skew (
    .clk      (clk),
    .rstn     (rstn),
    .lane0_in (cmd0_q),
    .lane_out (command_array)
  );

  // Writeback is issued at lane-0 timing; the psum buffer applies its own skew.
  assign psum_wr_en   = ret_q[PIPE_LAT] && !tag_last_q[PIPE_LAT];
  assign psum_wr_addr = tag_row_q[PIPE_LAT];
  assign out_valid    = ret_q[PIPE_LAT] && tag_last_q[PIPE_LAT];
  assign out_addr     = tag_row_q[PIPE_LAT];
  assign busy         = (state_q != SEQ_IDLE);
  assign err_overrun  = err_q;
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_accum_sequencer.sv
// Directed bench for accum_sequencer: a beat-timeline reference model checked
// every cycle, plus literal timing expectations for each tile scenario.
module tb_accum_sequencer;
  import accum_sequencer_pkg::*;

  localparam int NUM_DATA    = 4;
  localparam int ADD_LATENCY = 8;
  localparam int PIPE_LAT    = ADD_LATENCY + 2;
  localparam int ROW_W       = 8;
  localparam int PASS_W      = 16;
  localparam int WB_OFF      = 1 + PIPE_LAT;                 // beat -> writeback
  localparam int RET_OFF     = 1 + PIPE_LAT + NUM_DATA - 1;  // beat -> last lane retires
  localparam int MAXC        = 8192;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic cfg_valid = 1'b0;
  logic cfg_ready;
  logic [ROW_W-1:0]  cfg_rows = '0;
  logic [PASS_W-1:0] cfg_passes = '0;
  logic mxu_valid = 1'b0;
  logic mxu_ready;
  logic [ACCUM_COMMAND_WIDTH-1:0] command_array [0:NUM_DATA-1];
  logic psum_rd_en, psum_wr_en, out_valid, busy, done, err_overrun;
  logic [ROW_W-1:0] psum_rd_addr, psum_wr_addr, out_addr;
  logic [1:0] dbg_state;

  accum_sequencer #(
    .NUM_DATA(NUM_DATA), .ADD_LATENCY(ADD_LATENCY), .ROW_W(ROW_W), .PASS_W(PASS_W)
  ) dut (
    .clk(clk), .rstn(rstn),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_rows(cfg_rows), .cfg_passes(cfg_passes),
    .mxu_valid(mxu_valid), .mxu_ready(mxu_ready), .command_array(command_array),
    .psum_rd_en(psum_rd_en), .psum_rd_addr(psum_rd_addr),
    .psum_wr_en(psum_wr_en), .psum_wr_addr(psum_wr_addr),
    .out_valid(out_valid), .out_addr(out_addr),
    .busy(busy), .done(done), .err_overrun(err_overrun), .dbg_state(dbg_state)
  );

  // ---------------- clock / cycle count ----------------
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad = 0;
  int base = 0;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cycle=%0d got=%0d expected=%0d", name, cyc, act, exp);
    end
  endtask

  // ---------------- reference model (beat timeline) ----------------
  bit m_idle = 1'b1, m_run = 1'b0, m_err = 1'b0;
  int m_rows = 0, m_passes = 0, m_r = 0, m_p = 0, m_done_cyc = -1;
  bit beat_v   [MAXC];
  bit beat_fin [MAXC];
  int beat_row [MAXC];
  int beat_pass[MAXC];

  // observed events, relative to base
  logic [15:0] ev_acc[$];
  logic [15:0] ev_out[$];
  logic [15:0] ev_oaddr[$];
  logic [15:0] ev_l3[$];
  logic [15:0] exp_q[$];
  int ev_rd[$];
  int ev_wr[$];
  int done_rel = -1;

  int c, inf, t, exp_cmd;
  bit exp_rdy, acc, fin;

  always @(negedge clk) begin
    if (!rstn) begin
      check("rst_cfg_ready", cfg_ready, 1);
      check("rst_mxu_ready", mxu_ready, 0);
      check("rst_psum_rd_en", psum_rd_en, 0);
      check("rst_psum_wr_en", psum_wr_en, 0);
      check("rst_out_valid", out_valid, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_err", err_overrun, 0);
      for (int g = 0; g < NUM_DATA; g++)
        check($sformatf("rst_lane%0d", g), command_array[g], ACCUMULATOR_COMMAND_IDLE);
      m_idle = 1'b1; m_run = 1'b0; m_err = 1'b0; m_done_cyc = -1; m_r = 0; m_p = 0;
      for (int i = 0; i < MAXC; i++) beat_v[i] = 1'b0;
    end else begin
      c = cyc;
      inf = 0;
      for (int k = 1; k <= RET_OFF; k++)
        if (c - k >= 0 && beat_v[c-k]) inf++;
      exp_rdy = m_run && (m_p == 0 || inf < m_rows);
      acc = exp_rdy && mxu_valid;

      check("cfg_ready", cfg_ready, m_idle);
      check("mxu_ready", mxu_ready, exp_rdy);
      check("psum_rd_en", psum_rd_en, acc && m_p > 0);
      if (acc && m_p > 0) check("psum_rd_addr", psum_rd_addr, m_r);
      for (int g = 0; g < NUM_DATA; g++) begin
        t = c - 1 - g;
        exp_cmd = ACCUMULATOR_COMMAND_IDLE;
        if (t >= 0 && beat_v[t])
          exp_cmd = (beat_pass[t] == 0) ? ACCUMULATOR_COMMAND_NEW_ACCUM : ACCUMULATOR_COMMAND_ACCUM;
        check($sformatf("lane%0d", g), command_array[g], exp_cmd);
      end
      t = c - WB_OFF;
      check("psum_wr_en", psum_wr_en, t >= 0 && beat_v[t] && !beat_fin[t]);
      check("out_valid", out_valid, t >= 0 && beat_v[t] && beat_fin[t]);
      if (t >= 0 && beat_v[t]) begin
        if (beat_fin[t]) check("out_addr", out_addr, beat_row[t]);
        else             check("psum_wr_addr", psum_wr_addr, beat_row[t]);
      end
      check("busy", busy, !m_idle);
      check("done", done, c == m_done_cyc);
      check("err_overrun", err_overrun, m_err);

      // observed event log
      if (mxu_valid && mxu_ready) ev_acc.push_back(16'(c - base));
      if (out_valid) begin ev_out.push_back(16'(c - base)); ev_oaddr.push_back(16'(out_addr)); end
      if (command_array[3] == ACCUMULATOR_COMMAND_NEW_ACCUM) ev_l3.push_back(16'(c - base));
      if (psum_rd_en) ev_rd.push_back(c);
      if (psum_wr_en) ev_wr.push_back(c);
      if (done) done_rel = c - base;

      // advance model to next cycle
      if (m_idle && cfg_valid) begin
        m_err = 1'b0;
        m_idle = 1'b0;
        m_rows = int'(cfg_rows); m_passes = int'(cfg_passes); m_r = 0; m_p = 0;
        if (m_rows == 0 || m_passes == 0) m_done_cyc = c + 1;
        else m_run = 1'b1;
      end
      if (mxu_valid && !m_run) m_err = 1'b1;
      if (acc) begin
        fin = (m_p == m_passes - 1);
        beat_v[c] = 1'b1; beat_row[c] = m_r; beat_pass[c] = m_p; beat_fin[c] = fin;
        if (m_r == m_rows - 1) begin
          m_r = 0; m_p++;
          if (fin) begin m_run = 1'b0; m_done_cyc = c + RET_OFF + 2; end
        end else m_r++;
      end
      if (c == m_done_cyc) begin m_idle = 1'b1; m_done_cyc = -1; end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic clear_ev();
    ev_acc.delete(); ev_out.delete(); ev_oaddr.delete(); ev_l3.delete();
    ev_rd.delete(); ev_wr.delete(); exp_q.delete(); done_rel = -1;
  endtask

  task automatic cfg(input int rows, input int passes);
    @(posedge clk); #1;
    cfg_valid = 1'b1; cfg_rows = ROW_W'(rows); cfg_passes = PASS_W'(passes);
    @(posedge clk); #1;
    cfg_valid = 1'b0;
    base = cyc;
  endtask

  task automatic stream(input int n, input int budget);
    int got = 0;
    int k = 0;
    mxu_valid = 1'b1;
    while (got < n && k < budget) begin
      @(negedge clk); if (mxu_ready) got++;
      @(posedge clk); #1; k++;
    end
    mxu_valid = 1'b0;
    check("stream_beats", got, n);
  endtask

  task automatic wait_done(input int budget);
    bit seen = 1'b0;
    int k = 0;
    while (!seen && k < budget) begin
      @(negedge clk); if (done) seen = 1'b1; k++;
    end
    check("done_seen", seen, 1);
    @(posedge clk); #1;
  endtask

  // sel: 0 accepts, 1 out cycles, 2 out addrs, 3 lane-3 NEW cycles
  task automatic cmp_seq(input string name, input int sel);
    int n;
    int obs;
    n = (sel == 0) ? ev_acc.size() : (sel == 1) ? ev_out.size() :
        (sel == 2) ? ev_oaddr.size() : ev_l3.size();
    check({name, "_len"}, n, exp_q.size());
    for (int i = 0; i < exp_q.size() && i < n; i++) begin
      obs = (sel == 0) ? int'(ev_acc[i]) : (sel == 1) ? int'(ev_out[i]) :
            (sel == 2) ? int'(ev_oaddr[i]) : int'(ev_l3[i]);
      check($sformatf("%s[%0d]", name, i), obs, int'(exp_q[i]));
    end
    exp_q.delete();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    repeat (3) @(posedge clk);
    #1 rstn = 1'b1;

    // rows=4, passes=1
    clear_ev();
    cfg(4, 1);
    stream(4, 50);
    wait_done(100);
    for (int i = 0; i < 4; i++) exp_q.push_back(16'(i));      cmp_seq("t1_acc", 0);
    for (int i = 11; i <= 14; i++) exp_q.push_back(16'(i));   cmp_seq("t1_out", 1);
    for (int i = 0; i < 4; i++) exp_q.push_back(16'(i));      cmp_seq("t1_oaddr", 2);
    for (int i = 4; i <= 7; i++) exp_q.push_back(16'(i));     cmp_seq("t1_lane3", 3);
    check("t1_done_cycle", done_rel, 19);
    check("t1_rd_cnt", ev_rd.size(), 0);
    check("t1_wr_cnt", ev_wr.size(), 0);

    // rows=8, passes=3
    clear_ev();
    cfg(8, 3);
    stream(24, 200);
    wait_done(200);
    for (int i = 0; i < 8; i++)   exp_q.push_back(16'(i));
    for (int i = 15; i < 23; i++) exp_q.push_back(16'(i));
    for (int i = 30; i < 38; i++) exp_q.push_back(16'(i));
    cmp_seq("t2_acc", 0);
    for (int i = 0; i < 8; i++) exp_q.push_back(16'(i));      cmp_seq("t2_oaddr", 2);
    check("t2_rd_cnt", ev_rd.size(), 16);
    check("t2_wr_cnt", ev_wr.size(), 16);
    check("t2_done_cycle", done_rel, 53);

    // rows=1, passes=4
    clear_ev();
    cfg(1, 4);
    stream(4, 100);
    wait_done(100);
    for (int i = 0; i < 4; i++) exp_q.push_back(16'(15 * i)); cmp_seq("t3_acc", 0);
    check("t3_rd_cnt", ev_rd.size(), 3);
    check("t3_wr_cnt", ev_wr.size(), 3);
    for (int i = 0; i < 3 && i < ev_rd.size() && i < ev_wr.size(); i++)
      check($sformatf("t3_raw_gap%0d", i), ev_rd[i] > ev_wr[i], 1);
    check("t3_done_cycle", done_rel, 61);

    // rows=0, passes=5
    clear_ev();
    cfg(0, 5);
    wait_done(10);
    check("t4_done_cycle", done_rel, 0);
    check("t4_acc_cnt", ev_acc.size(), 0);
    check("t4_out_cnt", ev_out.size(), 0);

    // mxu_valid in IDLE
    clear_ev();
    @(posedge clk); #1 mxu_valid = 1'b1;
    @(posedge clk); #1 mxu_valid = 1'b0;
    #1 check("t5_err_set", err_overrun, 1);
    repeat (3) @(posedge clk);
    #2 check("t5_err_sticky", err_overrun, 1);
    cfg(2, 1);
    #1 check("t5_err_cleared", err_overrun, 0);
    stream(2, 50);
    wait_done(100);
    check("t5_out_cnt", ev_out.size(), 2);

    // reset mid-RUN at cycle 5 of rows=8 passes=3
    clear_ev();
    cfg(8, 3);
    mxu_valid = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    rstn = 1'b0;
    mxu_valid = 1'b0;
    #1;
    check("t6_busy", busy, 0);
    for (int g = 0; g < NUM_DATA; g++)
      check($sformatf("t6_lane%0d", g), command_array[g], ACCUMULATOR_COMMAND_IDLE);
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;
    clear_ev();
    cfg(2, 2);
    stream(4, 100);
    wait_done(100);
    exp_q.push_back(16'd0); exp_q.push_back(16'd1);
    exp_q.push_back(16'd15); exp_q.push_back(16'd16);
    cmp_seq("t6_acc", 0);
    exp_q.push_back(16'd0); exp_q.push_back(16'd1);
    cmp_seq("t6_oaddr", 2);
    check("t6_rd_cnt", ev_rd.size(), 2);
    check("t6_wr_cnt", ev_wr.size(), 2);
    check("t6_done_cycle", done_rel, 32);

    repeat (2) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog cycle=%0d got=timeout expected=finish", cyc);
    $fatal(1, "watchdog");
  end

endmodule
